// File: rtl/shr_arb_pkg.sv
// Shared definitions for the shr_arb shift-arbiter slice: FSM state encoding and
// a constant clog2 helper used to size the stage counter.
package shr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shr_arb_rr.sv
// shr_rr_arb: NREQ-wide round-robin arbiter. Priority starts at the index just
// after rr_ptr and wraps; produces a one-hot grant and its encoded index.
module shr_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Two ascending passes: indices above rr_ptr first, then the wrapped remainder.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IDW'(i) > rr_ptr)) begin
        grant[i] = 1'b1;
        idx      = IDW'(i);
        any      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IDW'(i) <= rr_ptr)) begin
        grant[i] = 1'b1;
        idx      = IDW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shr_arb.sv
// shr_arb: one iterative shift-right datapath shared by NREQ requesters.
// Round-robin grant in IDLE, one barrel stage per clock in SHIFT, a finalize
// cycle that applies shift-amount overflow, then the result is held in DONE
// until the consumer accepts it.
// Optional feature: define SHR_ARB_ARITH_EN to add req_arith (arithmetic shift).
module shr_arb
  import shr_arb_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_sh,
`ifdef SHR_ARB_ARITH_EN
  input  logic [NREQ-1:0]           req_arith,
`endif
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  output logic [DATAWIDTH-1:0]      out_d,
  output logic [IDW-1:0]            out_id,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned SW = clog2(DATAWIDTH);
  localparam int unsigned KW = clog2(SW + 1);
  localparam logic [DATAWIDTH-1:0] ALL_ONES = '1;

  state_t               state_q;
  state_t               state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       gidx;
  logic                 gany;
  logic                 accept;
  logic                 last_stage;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_sh;
  logic [DATAWIDTH-1:0] acc_q;
  logic [DATAWIDTH-1:0] stage_acc;
  logic [SW-1:0]        sh_q;
  logic                 ovf_q;
  logic [IDW-1:0]       id_q;
  logic [KW-1:0]        k_q;
  logic                 fill_bit;

  shr_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .idx    (gidx),
    .any    (gany)
  );

  assign sel_a      = req_a[32'(gidx) * DATAWIDTH +: DATAWIDTH];
  assign sel_sh     = req_sh[32'(gidx) * DATAWIDTH +: DATAWIDTH];
  assign accept     = (state_q == ST_IDLE) && gany;
  assign last_stage = (k_q == KW'(SW));

`ifdef SHR_ARB_ARITH_EN
  logic arith_q;
  // Sign fill tracks the accumulator MSB, which an arithmetic shift preserves.
  assign fill_bit = arith_q & acc_q[DATAWIDTH-1];

  // Arithmetic-mode flag captured with the operand.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      arith_q <= 1'b0;
    end else if (accept) begin
      arith_q <= req_arith[gidx];
    end
  end
`else
  assign fill_bit = 1'b0;
`endif

  // Barrel stage k: shift by 2**k when sh[k] is set, fill vacated bits.
  always_comb begin
    stage_acc = acc_q;
    for (int unsigned s = 0; s < SW; s++) begin
      if ((k_q == KW'(s)) && sh_q[s]) begin
        stage_acc = (acc_q >> (1 << s)) |
                    ({DATAWIDTH{fill_bit}} & ~(ALL_ONES >> (1 << s)));
      end
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gany)       state_d = ST_SHIFT;
      ST_SHIFT: if (last_stage) state_d = ST_DONE;
      ST_DONE:  if (out_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; grants are only offered while idle.
  always_comb begin
    req_ready = '0;
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    if (state_q == ST_IDLE) begin
      req_ready = grant;
    end
  end

  // Operand capture, per-stage accumulate, and result register load.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q    <= '0;
      sh_q     <= '0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
      k_q      <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
      out_d    <= '0;
      out_id   <= '0;
    end else if (accept) begin
      acc_q    <= sel_a;
      sh_q     <= sel_sh[SW-1:0];
      ovf_q    <= ((sel_sh >> SW) != '0);
      id_q     <= gidx;
      k_q      <= '0;
      rr_ptr_q <= gidx;
    end else if (state_q == ST_SHIFT) begin
      if (last_stage) begin
        out_d  <= ovf_q ? {DATAWIDTH{fill_bit}} : acc_q;
        out_id <= id_q;
      end else begin
        acc_q <= stage_acc;
        k_q   <= k_q + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shr_arb.sv
// Scoreboard bench for shr_arb: stimulus pushes hand-computed results at grant
// time, a negedge monitor pops and compares on every result handshake.
module tb_shr_arb;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [IDW-1:0] id;
  } exp_t;

  logic                 Clk;
  logic                 Rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_sh;
`ifdef SHR_ARB_ARITH_EN
  logic [NREQ-1:0]      req_arith;
`endif
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_d;
  logic [IDW-1:0]       out_id;
  logic                 out_ready;
  logic                 busy;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  shr_arb #(
    .DATAWIDTH (DW),
    .NREQ      (NREQ),
    .IDW       (IDW)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_sh    (req_sh),
`ifdef SHR_ARB_ARITH_EN
    .req_arith (req_arith),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_d     (out_d),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input int id);
    exp_t e;
    e.d  = d;
    e.id = IDW'(id);
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for out_valid, then lets the handshake edge pass if ready.
  task automatic wait_result();
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge Clk); #1;
      c++;
    end
    check("result_timeout", 32'(out_valid), 32'd1);
    if (out_ready) begin
      @(posedge Clk); #1;
    end
  endtask

  // Single requester issue from IDLE; expected result pushed before the accept edge.
  task automatic run_one(input int id, input logic [DW-1:0] a, input logic [DW-1:0] sh,
                         input logic [DW-1:0] exp_d);
    req_a[id*DW +: DW]  = a;
    req_sh[id*DW +: DW] = sh;
    req_valid[id]       = 1'b1;
    #1;
    check("grant_single", 32'(req_ready), 32'(1 << id));
    push(exp_d, id);
    @(posedge Clk); #1;
    req_valid[id] = 1'b0;
    wait_result();
  endtask

  // Monitor: compare every result handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_d", 32'(out_d), 32'(e.d));
          check("out_id", 32'(out_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    int c;
    checks    = 0;
    errors    = 0;
    Rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_sh    = '0;
`ifdef SHR_ARB_ARITH_EN
    req_arith = '0;
`endif
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_d", 32'(out_d), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // 1: req0 F0>>3 = 1E, result visible after accept edge + 4
    req_a[0 +: DW]  = 8'hF0;
    req_sh[0 +: DW] = 8'h03;
    req_valid[0]    = 1'b1;
    #1;
    check("t1_grant", 32'(req_ready), 32'h1);
    push(8'h1E, 0);
    @(posedge Clk); #1;
    req_valid[0] = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge Clk); #1;
      check("t1_early_valid", 32'(out_valid), 32'd0);
    end
    @(posedge Clk); #1;
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    @(posedge Clk); #1;
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: all four continuously valid after reset -> grants 0,1,2,3,0
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    req_a  = {8'hFE, 8'hA5, 8'h3C, 8'h81};
    req_sh = {8'h07, 8'h05, 8'h02, 8'h01};
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      int gi;
      logic [DW-1:0] ed;
      gi = g % 4;
      case (gi)
        0:       ed = 8'h40;
        1:       ed = 8'h0F;
        2:       ed = 8'h05;
        default: ed = 8'h01;
      endcase
      c = 0;
      #1;
      while (req_ready == '0 && c < 20) begin
        @(posedge Clk); #1;
        c++;
      end
      check("t2_grant_order", 32'(req_ready), 32'(1 << gi));
      push(ed, gi);
      @(posedge Clk); #1;
    end
    req_valid = '0;
    wait_result();

    // 3: overflow and boundary shift amounts
    run_one(1, 8'hFF, 8'h08, 8'h00);
    run_one(2, 8'h5A, 8'h00, 8'h5A);
    run_one(3, 8'hFF, 8'h81, 8'h00);
    run_one(0, 8'h80, 8'h07, 8'h01);

    // 4: consumer stalls five cycles in DONE with another request pending
    out_ready = 1'b0;
    run_one(3, 8'hC3, 8'h01, 8'h61);
    req_a[0 +: DW]  = 8'h0F;
    req_sh[0 +: DW] = 8'h02;
    req_valid[0]    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_d", 32'(out_d), 32'h61);
      check("t4_hold_id", 32'(out_id), 32'd3);
      check("t4_no_grant", 32'(req_ready), 32'd0);
    end
    push(8'h03, 0);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    check("t4_regrant", 32'(req_ready), 32'h1);
    @(posedge Clk); #1;
    req_valid[0] = 1'b0;
    wait_result();

    // 5: reset during SHIFT aborts, then requester 0 wins first
    req_a[2*DW +: DW]  = 8'hF0;
    req_sh[2*DW +: DW] = 8'h01;
    req_valid[2]       = 1'b1;
    #1;
    check("t5_grant", 32'(req_ready), 32'h4);
    @(posedge Clk); #1;
    req_valid[2] = 1'b0;
    @(posedge Clk); #1;
    check("t5_shifting", 32'(busy), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_d", 32'(out_d), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    req_a  = {8'h11, 8'h22, 8'h33, 8'hAA};
    req_sh = {8'h01, 8'h01, 8'h01, 8'h04};
    req_valid = 4'hF;
    #1;
    check("t5_first_grant", 32'(req_ready), 32'h1);
    push(8'h0A, 0);
    @(posedge Clk); #1;
    req_valid = '0;
    wait_result();

`ifdef SHR_ARB_ARITH_EN
    // 6: arithmetic versus logical fill
    req_arith[1] = 1'b1;
    run_one(1, 8'h80, 8'h02, 8'hE0);
    run_one(1, 8'h80, 8'h10, 8'hFF);
    req_arith[1] = 1'b0;
    run_one(1, 8'h80, 8'h02, 8'h20);
`endif

    repeat (5) @(posedge Clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
